// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and axis-segment helpers for the VGA raster timing generator.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [COORD_W-1:0] vga_coord_t;

  typedef enum logic [1:0] {
    SEG_VISIBLE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } vga_seg_e;

  function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  // Region of an axis that a coordinate falls into; the back porch runs up to total-1.
  function automatic vga_seg_e axis_segment(input vga_coord_t c, input int visible,
                                            input int fp, input int sync);
    int ci;
    ci = int'(c);
    if (ci < visible) begin
      return SEG_VISIBLE;
    end else if (ci < visible + fp) begin
      return SEG_FRONT;
    end else if (ci < visible + fp + sync) begin
      return SEG_SYNC;
    end
    return SEG_BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync level and the
// next-state visible/wrap decodes the top uses to keep all outputs skew-free.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE = H_VISIBLE_DEF,
  parameter int   FP      = H_FP_DEF,
  parameter int   SYNC    = H_SYNC_DEF,
  parameter int   BP      = H_BP_DEF,
  parameter logic POL     = SYNC_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       en_i,
  output vga_coord_t count_o,
  output logic       wrap_o,
  output logic       sync_o,
  output logic       visible_next_o
);

  localparam int         TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
  localparam vga_coord_t LAST  = vga_coord_t'(TOTAL - 1);

  vga_coord_t count_q;
  vga_coord_t count_d;
  logic       sync_q;
  logic       sync_d;
  logic       wrap;
  vga_seg_e   seg_d;

  always_comb begin
    wrap    = en_i && !srst && (count_q == LAST);
    count_d = count_q;
    if (srst) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap ? '0 : count_q + vga_coord_t'(1);
    end
    // Decoding the next count lets the sync register line up with the count register.
    seg_d  = axis_segment(count_d, VISIBLE, FP, SYNC);
    sync_d = (!srst && (seg_d == SEG_SYNC)) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o        = count_q;
  assign wrap_o         = wrap;
  assign sync_o         = sync_q;
  assign visible_next_o = (seg_d == SEG_VISIBLE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: DrawX/DrawY, blank, hs/vs, line/frame start pulses, all aligned to the same pixel.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic        vga_clk,
  input  logic        reset,
  output vga_coord_t  DrawX,
  output vga_coord_t  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end

  logic h_wrap;
  logic v_wrap;
  logic h_vis_next;
  logic v_vis_next;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (SYNC_POL)
  ) u_h (
    .clk            (vga_clk),
    .srst           (reset),
    .en_i           (1'b1),
    .count_o        (DrawX),
    .wrap_o         (h_wrap),
    .sync_o         (hs),
    .visible_next_o (h_vis_next)
  );

  // The vertical axis only moves on the edge where the line wraps, so vs changes only at DrawX==0.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (SYNC_POL)
  ) u_v (
    .clk            (vga_clk),
    .srst           (reset),
    .en_i           (h_wrap),
    .count_o        (DrawY),
    .wrap_o         (v_wrap),
    .sync_o         (vs),
    .visible_next_o (v_vis_next)
  );

  logic blank_q;
  logic blank_d;
  logic line_start_q;
  logic line_start_d;
  logic frame_start_q;
  logic frame_start_d;

  // Wrap flags are already masked by reset, so they double as next-state "coordinate is 0" decodes.
  always_comb begin
    blank_d       = h_vis_next && v_vis_next;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule
